// File: rtl/uart_rx_fifo.sv
// UART receiver (8N1, or 8E1 when UART_RX_PARITY_EN is defined) feeding a show-ahead FIFO
// with sticky overrun / framing / parity error flags.
module uart_rx_fifo #(
  parameter int BIT_CLKS   = 217,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          rx,
  input  logic                          rd_en,
  input  logic                          err_clr,
  output logic [7:0]                    rd_data,
  output logic                          rx_valid,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overrun,
  output logic                          frame_err,
  output logic                          parity_err
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(BIT_CLKS);
  localparam logic [CW-1:0] HALF_LD = CW'(BIT_CLKS / 2 - 1);
  localparam logic [CW-1:0] FULL_LD = CW'(BIT_CLKS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_e;

  logic          rx_m_q, rx_s, rx_d;
  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic [2:0]    bit_idx_q;
  logic [7:0]    shift_q;
  logic          frame_err_q, overrun_q;
  logic [AW:0]   wptr_q, rptr_q;
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic          push, pop, full, empty, accept;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_m_q <= 1'b1;
      rx_s   <= 1'b1;
      rx_d   <= 1'b1;
    end else begin
      rx_m_q <= rx;
      rx_s   <= rx_m_q;
      rx_d   <= rx_s;
    end
  end

  // Push fires on the stop-sample edge itself, so the FIFO sees it in the same cycle.
  assign push = (state_q == S_STOP) && (cnt_q == '0) && rx_s;

`ifdef UART_RX_PARITY_EN
  logic parity_err_q;
  assign parity_err = parity_err_q;
`else
  assign parity_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      bit_idx_q    <= '0;
      shift_q      <= '0;
      frame_err_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err_q <= 1'b0;
`endif
    end else begin
      // Clear first; a set later in this block overrides it.
      if (err_clr) begin
        frame_err_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
        parity_err_q <= 1'b0;
`endif
      end
      case (state_q)
        S_IDLE: begin
          if (rx_d && !rx_s) begin
            cnt_q   <= HALF_LD;
            state_q <= S_START;
          end
        end
        S_START: begin
          if (cnt_q == '0) begin
            if (rx_s) begin
              state_q <= S_IDLE;
            end else begin
              cnt_q     <= FULL_LD;
              bit_idx_q <= '0;
              state_q   <= S_DATA;
            end
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        S_DATA: begin
          if (cnt_q == '0) begin
            shift_q   <= {rx_s, shift_q[7:1]};
            cnt_q     <= FULL_LD;
            bit_idx_q <= bit_idx_q + 3'd1;
            if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state_q <= S_PARITY;
`else
              state_q <= S_STOP;
`endif
            end
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
`ifdef UART_RX_PARITY_EN
        S_PARITY: begin
          if (cnt_q == '0) begin
            if (rx_s != ^shift_q) parity_err_q <= 1'b1;
            cnt_q   <= FULL_LD;
            state_q <= S_STOP;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
`endif
        S_STOP: begin
          if (cnt_q == '0) begin
            if (!rx_s) frame_err_q <= 1'b1;
            state_q <= S_IDLE;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign empty  = (wptr_q == rptr_q);
  assign full   = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign pop    = rd_en && !empty;
  // A pop in the same cycle frees the slot a full FIFO needs.
  assign accept = push && (!full || pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q    <= '0;
      rptr_q    <= '0;
      overrun_q <= 1'b0;
    end else begin
      if (err_clr) overrun_q <= 1'b0;
      if (push && !accept) overrun_q <= 1'b1;
      if (pop) rptr_q <= rptr_q + 1'b1;
      if (accept) wptr_q <= wptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) mem_q[wptr_q[AW-1:0]] <= shift_q;
  end

  assign rd_data    = empty ? 8'h00 : mem_q[rptr_q[AW-1:0]];
  assign rx_valid   = !empty;
  assign fifo_count = wptr_q - rptr_q;
  assign overrun    = overrun_q;
  assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed + randomized bench for uart_rx_fifo; expectations come from a byte-queue model.
module tb_uart_rx_fifo;
  localparam int BC = 16;
  localparam int D  = 4;
`ifdef UART_RX_PARITY_EN
  localparam int FB = 11;
`else
  localparam int FB = 10;
`endif
  // Edges from the rx fall to the stop-sample edge: 3 sync/detect + half bit + (FB-1) bits.
  localparam int STOP_EDGE = 3 + BC/2 + BC*(FB-1);

  logic       clk = 1'b0, rst = 1'b1, rx = 1'b1, rd_en = 1'b0, err_clr = 1'b0;
  logic [7:0] rd_data;
  logic       rx_valid, overrun, frame_err, parity_err;
  logic [2:0] fifo_count;

  int ncmp = 0, nfail = 0;
  byte unsigned mq[$];
  bit ov_m, fe_m, pe_m;

  uart_rx_fifo #(.BIT_CLKS(BC), .FIFO_DEPTH(D)) dut (
    .clk(clk), .rst(rst), .rx(rx), .rd_en(rd_en), .err_clr(err_clr),
    .rd_data(rd_data), .rx_valid(rx_valid), .fifo_count(fifo_count),
    .overrun(overrun), .frame_err(frame_err), .parity_err(parity_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic hold(input bit v, input int n);
    rx = v;
    repeat (n) tick();
  endtask

  task automatic send(input logic [7:0] b, input bit stop_ok, input bit par_bad);
    hold(1'b0, BC);
    for (int i = 0; i < 8; i++) hold(b[i], BC);
`ifdef UART_RX_PARITY_EN
    hold((^b) ^ par_bad, BC);
`endif
    hold(stop_ok, BC);
  endtask

  function automatic void model_rx(input logic [7:0] b);
    if (mq.size() < D) mq.push_back(b);
    else ov_m = 1'b1;
  endfunction

  task automatic check_state(input string tag);
    chk({tag, ".count"}, 32'(fifo_count), 32'(mq.size()));
    chk({tag, ".valid"}, 32'(rx_valid), 32'(mq.size() != 0));
    chk({tag, ".rd_data"}, 32'(rd_data), (mq.size() != 0) ? 32'(mq[0]) : 32'h0);
    chk({tag, ".overrun"}, 32'(overrun), 32'(ov_m));
    chk({tag, ".frame_err"}, 32'(frame_err), 32'(fe_m));
    chk({tag, ".parity_err"}, 32'(parity_err), 32'(pe_m));
  endtask

  task automatic pop_n(input string tag, input int n);
    for (int i = 0; i < n && mq.size() != 0; i++) begin
      rd_en = 1'b1;
      chk($sformatf("%s.pop%0d", tag, i), 32'(rd_data), 32'(mq[0]));
      void'(mq.pop_front());
      tick();
    end
    rd_en = 1'b0;
  endtask

  task automatic drain(input string tag);
    pop_n(tag, D);
    check_state({tag, ".drained"});
  endtask

  task automatic clr();
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    ov_m = 0; fe_m = 0; pe_m = 0;
  endtask

  initial begin
    logic [7:0] b;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check_state("reset");

    // Single byte with exact latency
    fork
      send(8'hA5, 1'b1, 1'b0);
      begin
        repeat (STOP_EDGE - 1) @(posedge clk);
        #1 chk("lat.before", 32'(rx_valid), 32'h0);
        @(posedge clk);
        #1 chk("lat.at", 32'(rx_valid), 32'h1);
      end
    join
    model_rx(8'hA5);
    check_state("single");
    drain("single");

    // Glitch
    hold(1'b0, 4);
    hold(1'b1, 3 * BC);
    check_state("glitch");

    // Framing error, held break, clear
    send(8'h3C, 1'b0, 1'b0);
    fe_m = 1'b1;
    check_state("frame");
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    fe_m = 1'b0;
    check_state("frame.clr");
    hold(1'b0, 40 * BC);
    hold(1'b1, 2 * BC);
    check_state("break");

    // Overrun
    for (int i = 1; i <= 5; i++) begin
      send(8'(i), 1'b1, 1'b0);
      model_rx(8'(i));
    end
    check_state("overrun");
    drain("overrun");

    // Full FIFO, pop on the stop-sample edge of the fifth byte
    clr();
    for (int i = 0; i < D; i++) begin
      b = 8'($urandom_range(0, 255));
      send(b, 1'b1, 1'b0);
      model_rx(b);
    end
    fork
      send(8'h06, 1'b1, 1'b0);
      begin
        repeat (STOP_EDGE - 1) @(posedge clk);
        #1 rd_en = 1'b1;
        chk("fullpp.head", 32'(rd_data), 32'(mq[0]));
        @(posedge clk);
        #1 rd_en = 1'b0;
      end
    join
    void'(mq.pop_front());
    mq.push_back(8'h06);
    check_state("fullpp");
    drain("fullpp");

`ifdef UART_RX_PARITY_EN
    send(8'h07, 1'b1, 1'b0);
    model_rx(8'h07);
    check_state("par.good");
    send(8'h07, 1'b1, 1'b1);
    model_rx(8'h07);
    pe_m = 1'b1;
    check_state("par.bad");
    clr();
    drain("par");
`endif

    // Reset during data bit 4 with a byte already queued
    send(8'h9E, 1'b1, 1'b0);
    model_rx(8'h9E);
    hold(1'b0, BC);
    for (int i = 0; i < 4; i++) hold(1'(i & 1), BC);
    hold(1'b1, BC/2);
    rst = 1'b1; tick(); rst = 1'b0;
    hold(1'b1, 2 * BC);
    mq.delete(); ov_m = 0; fe_m = 0; pe_m = 0;
    check_state("rstmid");
    send(8'h55, 1'b1, 1'b0);
    model_rx(8'h55);
    check_state("post_rst");
    drain("post_rst");

    // Randomized traffic with interleaved pops
    for (int n = 0; n < 12; n++) begin
      b = 8'($urandom_range(0, 255));
      send(b, 1'b1, 1'b0);
      model_rx(b);
      repeat ($urandom_range(0, 3)) tick();
      if ($urandom_range(0, 2) == 0) pop_n($sformatf("rnd%0d", n), $urandom_range(1, 2));
      check_state($sformatf("rnd%0d", n));
    end
    drain("rnd");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

- Receive-side UART stage for the RV32I core: turns the asynchronous `rx` pin into bytes buffered in a small FIFO for the core's UART register interface.
- Does 2-flop synchronisation, start-bit qualification, mid-bit sampling of 8N1 frames, push into a show-ahead FIFO, and sticky overrun/framing error flags.
- Sits between the chip-level `rx` input and the core's memory-mapped UART read path. It is the mirror of the existing transmit path.

## Interface
Parameters:
- `BIT_CLKS`, default 217: clocks per bit (25 MHz / 115200). Must be ≥ 4.
- `FIFO_DEPTH`, default 4: entries. Power of two, ≥ 2.

Ports:
- `clk`  in  1  sole clock
- `rst`  in  1  reset; synchronous, active-high
- `rx`  in  1  asynchronous serial input, idle high
- `rd_en`  in  1  pop head entry this cycle
- `err_clr`  in  1  clear sticky error flags
- `rd_data`  out  8  FIFO head byte (show-ahead); 8'h00 when empty
- `rx_valid`  out  1  FIFO non-empty
- `fifo_count`  out  $clog2(FIFO_DEPTH)+1  current occupancy
- `overrun`  out  1  sticky: a byte was dropped because the FIFO was full
- `frame_err`  out  1  sticky: stop bit sampled low
- `parity_err`  out  1  sticky: parity mismatch; constant 0 when `UART_RX_PARITY_EN` is undefined

## Operation
- **Synchroniser.** `rx` passes through two flops, both reset to 1, giving `rx_s`. `rx_s` is registered once more as `rx_d` for edge detection.
- **FSM states:** IDLE, START, DATA, PARITY (only with the macro), STOP.
- **IDLE:** on `rx_d`=1 and `rx_s`=0, load the bit counter with BIT_CLKS/2−1 and go to START.
- **START:** at counter zero, sample `rx_s`.
  - If 1, treat as a glitch and return to IDLE.
  - If 0, load BIT_CLKS−1, clear the bit index and go to DATA.
- **DATA:** at each counter zero, shift `rx_s` into the shift register, LSB first, and reload BIT_CLKS−1. After bit index 7, go to PARITY (if enabled) or STOP.
- **PARITY:** at counter zero, compare `rx_s` with the XOR of the 8 data bits (even parity). On mismatch set `parity_err`; the byte is still pushed. Reload and go to STOP.
- **STOP:** at counter zero, sample `rx_s`, then return to IDLE.
  - 1: push the byte.
  - 0: set `frame_err` and discard the byte. A new start is only detected after `rx_s` has returned high (falling-edge requirement). A held break therefore yields one error only.
- **FIFO:** `wptr`/`rptr` are log2(DEPTH)+1 bits wide; full = MSBs differ and lower bits equal.
  - Push when full: set `overrun`, drop the new byte, keep existing contents.
  - Push and `rd_en` in the same cycle while full: pop first, push accepted, no overrun, count unchanged.
  - `rd_en` while empty: ignored; pointers unchanged.
  - Simultaneous push and pop while non-full: count unchanged.
- **Error flags:** `err_clr` clears all sticky flags. If a set event occurs in the same cycle as `err_clr`, set wins.
- **Reset** (any cycle, including mid-frame): FSM to IDLE, counter and bit index 0, pointers 0, flags 0, synchroniser flops 1. `rd_data` = 00, `rx_valid` = 0, `fifo_count` = 0. A partial frame is lost.

## Timing
- Synchroniser latency is 2 cycles. The falling edge is detected 3 cycles after the `rx` pin falls.
- With start detected at cycle T0 (IDLE→START transition at the edge following T0):
  - start sampled at T0+BIT_CLKS/2;
  - data bit k sampled at T0+BIT_CLKS/2+(k+1)·BIT_CLKS;
  - stop sampled at T0+BIT_CLKS/2+9·BIT_CLKS, plus BIT_CLKS more with parity.
- Push happens on the stop-sample clock edge. `rx_valid`, `fifo_count` and `rd_data` update on that edge.
- Pop: `rd_data` shows the next entry the cycle after the `rd_en` edge. No bubble; back-to-back pops are allowed.
- Error flags assert on the edge of the sampling cycle.

## Configuration
- `UART_RX_PARITY_EN` defined:
  - 8E1 frames;
  - PARITY state present;
  - `parity_err` live;
  - the stop bit is one bit time later.
- Undefined:
  - 8N1;
  - PARITY state removed from RTL;
  - `parity_err` tied to 0.

## Test plan
All scenarios use BIT_CLKS=16, FIFO_DEPTH=4.
- **Single byte:** send 8'hA5 8N1 → `rx_valid`=1 exactly 3+8+9·16 cycles after `rx` falls; `rd_data`=A5; `fifo_count`=1. Pop → `rx_valid`=0, `rd_data`=00.
- **Glitch:** low pulse of 4 cycles on idle `rx` → FSM returns to IDLE; no push; no flags.
- **Framing error:** send 8'h3C with stop=0 → `frame_err`=1, count 0. Then hold `rx` low 40 bit times → no second event. `err_clr` → `frame_err`=0.
- **Overrun:** send 5 bytes 01..05 without popping → count 4, `overrun`=1, pops return 01,02,03,04.
- **Full push+pop:** FIFO full, assert `rd_en` on the stop-sample cycle of byte 06 → no overrun, count stays 4, byte 06 is last out.
- **Parity (macro on):** 8'h07 with parity bit 1 → pushed, `parity_err`=0. With parity bit 0 → pushed, `parity_err`=1.
- **Reset mid-frame:** `rst` during DATA bit 4 → all outputs at reset values. The next full frame 8'h55 is received correctly.
